// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter: FSM state encodings.
// The optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_req_arbiter_pick.sv
// Combinational rotate-and-priority-encode: finds the first set request
// starting just above last_id and wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    localparam int SW = IDW + 1;

    logic [IDW-1:0]   cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester index visited at search step gi.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum       = {1'b0, last_id} + SW'(gi + 1);
            assign cand[gi]  = (sum >= SW'(N_REQ)) ? IDW'(sum - SW'(N_REQ)) : sum[IDW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        valid = |hit;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter FSM granting one shared resource to N_REQ requesters.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     release_i,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_e       state_q;
    logic [IDW-1:0]   last_id_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDW-1:0]   gnt_id_q;
    logic             busy_q;

    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic             owner_done;
    logic             hold_expired;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IDW'(gi));
        end
    endgenerate

    // Owner gives up the resource by dropping its request or pulsing release.
    assign owner_done = !req[gnt_id_q] || release_i;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_q;

    assign hold_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= (state_q == ST_GRANT) && hold_expired && !owner_done;
            if (state_q == ST_IDLE && pick_valid) begin
                hold_cnt_q <= '0;
            end else if (state_q == ST_GRANT) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_id_q <= IDW'(N_REQ - 1);
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q  <= ST_GRANT;
                        gnt_q    <= pick_onehot;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // A normal release and a forced release end the grant identically.
                    if (owner_done || hold_expired) begin
                        state_q   <= ST_GAP;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        last_id_q <= gnt_id_q;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule : rr_req_arbiter

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter (N_REQ=4, MAX_HOLD=8).
module tb_rr_req_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_req_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                             input logic e_busy, input logic e_to);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
        check({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        release_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req = '0;
        release_i = 1'b0;

        // 1: single requester grant and drop
        do_reset();
        check_all("t1_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("[TB] t1 reset checked");
        req = 4'b0001;
        tick();
        check_all("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        $display("[TB] t1 grant to 0 gnt=%b", gnt);
        req = 4'b0000;
        tick();
        check_all("t1_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("[TB] t1 drop gnt=%b busy=%b", gnt, busy);

        // 2: all requesting, rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_all($sformatf("t2_grant%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            check_all($sformatf("t2_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            tick();
            check_all($sformatf("t2_idle%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            tick();
            $display("[TB] t2 hand-off %0d done, gnt_id now %0d", k, gnt_id);
        end

        // 3: req drop and release together give a single gap, next owner 3
        do_reset();
        req = 4'b0100;
        tick();
        check_all("t3_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1100;
        tick();
        check_all("t3_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1000;
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        check_all("t3_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        check_all("t3_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        check_all("t3_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        $display("[TB] t3 next owner gnt_id=%0d", gnt_id);

        // 4: reset mid-grant, priority restarts at 0
        do_reset();
        req = 4'b0010;
        tick();
        check_all("t4_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        check_all("t4_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req = 4'b1010;
        tick();
        check_all("t4_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        $display("[TB] t4 after reset gnt_id=%0d", gnt_id);

        // 5: hold without release
        do_reset();
        req = 4'b0011;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            check_all($sformatf("t5_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
            if (c < 8) tick();
        end
        tick();
        check_all("t5_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_all("t5_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_all("t5_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        $display("[TB] t5 timeout hand-off to gnt_id=%0d", gnt_id);
`else
        for (int c = 1; c <= 55; c++) begin
            check_all($sformatf("t5_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
            tick();
        end
        $display("[TB] t5 grant held 55 cycles gnt=%b timeout=%b", gnt, timeout);
`endif

        // 6: release in idle with no requests does nothing
        do_reset();
        release_i = 1'b1;
        tick();
        check_all("t6_idle_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_all("t6_idle_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        release_i = 1'b0;
        req = 4'b0001;
        tick();
        check_all("t6_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        $display("[TB] t6 idle release ignored, later grant gnt=%b", gnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rr_req_arbiter
